// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - sequential PC fetch with credit-gated imem reads and a DEPTH-entry return queue
module fetch_queue_unit #(
    parameter int               XLEN     = 32,
    parameter int               IADDR_W  = 10,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h00000314,
    parameter int               DEPTH    = 4,
    localparam int              CW       = $clog2(DEPTH + 1),
    localparam int              PW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_data,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_instr,
    output logic [CW-1:0]      count
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic            kill;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;

    // Low target bits are forced to zero on redirect, so they are never consumed.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^redirect_target[1:0];

    // Credits: queued entries plus the outstanding read never exceed DEPTH.
    assign imem_req  = !rst && !redirect &&
                       ((CW+1)'(count_q) + (CW+1)'(inflight) < (CW+1)'(DEPTH));
    assign imem_addr = pc[IADDR_W-1:0];
    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? q_pc[head]    : '0;
    assign out_instr = out_valid ? q_instr[head] : '0;
    assign count     = count_q;

    assign push = inflight && !kill && !redirect;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
        end else begin
            inflight <= imem_req;
            kill     <= redirect && imem_req;
            if (redirect) begin
                pc      <= {redirect_target[XLEN-1:2], 2'b00};
                head    <= '0;
                tail    <= '0;
                count_q <= '0;
            end else begin
                if (imem_req) begin
                    pc     <= pc + XLEN'(XLEN / 8);
                    req_pc <= pc;
                end
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_pc[tail]    <= req_pc;
            q_instr[tail] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - scoreboard bench for fetch_queue_unit
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic [31:0] exp_q[$];

    fetch_queue_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .count           (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'hC0DE0000 + {22'h0, a};
    endfunction

    always @(posedge clk) begin
        imem_data <= imem_req ? mem_word(imem_addr) : 32'hDEADBEEF;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void refill(input logic [31:0] start);
        logic [31:0] p;
        exp_q.delete();
        p = start;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(p);
            p = p + 32'd4;
        end
    endfunction

    // Expected PC stream follows bench-driven reset/redirect; every head transfer is compared.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            refill(32'h314);
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'd0, 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_out_pc", out_pc, e);
                    check("sb_out_instr", out_instr, mem_word(e[9:0]));
                    pops++;
                end
            end
            if (redirect) refill({redirect_target[31:2], 2'b00});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_target = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_count", count, 3'd0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_req", imem_req, 1'b0);

        // Streaming from reset
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        pops = 0;
        for (int i = 0; i < 12; i++) begin
            check("t1_req", imem_req, 1'b1);
            check("t1_addr", imem_addr, 10'((32'h314 + 4 * i) & 32'h3FF));
            if (i < 2) check("t1_valid_lo", out_valid, 1'b0);
            else begin
                check("t1_valid_hi", out_valid, 1'b1);
                check("t1_out_pc", out_pc, 32'h314 + 4 * (i - 2));
            end
            step();
        end
        check("t1_pops", pops, 10);

        // Fill to DEPTH, single pop, single refill
        do_reset();
        for (int i = 0; i < 6; i++) begin
            check("t2_req", imem_req, (i < 4) ? 1'b1 : 1'b0);
            step();
        end
        check("t2_count_full", count, 3'd4);
        check("t2_out_pc", out_pc, 32'h314);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t2_count_after_pop", count, 3'd3);
        check("t2_reissue", imem_req, 1'b1);
        check("t2_reissue_addr", imem_addr, 10'h324);
        step();
        check("t2_no_issue_credit", imem_req, 1'b0);
        step();
        check("t2_count_refull", count, 3'd4);
        check("t2_head", out_pc, 32'h318);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Redirect at cycle 5 with a return and a pop in the same cycle
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        redirect = 1'b1;
        redirect_target = 32'h00000101;
        #1;
        check("t3_req_redirect", imem_req, 1'b0);
        step();
        redirect = 1'b0;
        #1;
        check("t3_count", count, 3'd0);
        check("t3_addr", imem_addr, 10'h100);
        check("t3_valid6", out_valid, 1'b0);
        step();
        check("t3_valid7", out_valid, 1'b0);
        step();
        check("t3_valid8", out_valid, 1'b1);
        check("t3_out_pc8", out_pc, 32'h100);
        for (int i = 0; i < 4; i++) step();

        // Redirect with a partly filled queue, return and pop together
        do_reset();
        for (int i = 0; i < 3; i++) step();
        check("t4_count_pre", count, 3'd2);
        out_ready = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h00000200;
        step();
        redirect = 1'b0;
        #1;
        check("t4_count", count, 3'd0);
        check("t4_valid", out_valid, 1'b0);
        step();
        step();
        check("t4_out_pc", out_pc, 32'h200);
        for (int i = 0; i < 3; i++) step();

        // Reset mid-operation with a read outstanding
        do_reset();
        for (int i = 0; i < 4; i++) step();
        check("t5_count_pre", count, 3'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t5_count", count, 3'd0);
        check("t5_valid", out_valid, 1'b0);
        check("t5_addr", imem_addr, 10'h314);
        out_ready = 1'b1;
        step();
        step();
        check("t5_out_pc", out_pc, 32'h314);
        for (int i = 0; i < 3; i++) step();

        // PC wrap
        redirect = 1'b1;
        redirect_target = 32'hFFFFFFFC;
        step();
        redirect = 1'b0;
        #1;
        check("t6_addr0", imem_addr, 10'h3FC);
        step();
        check("t6_addr1", imem_addr, 10'h000);
        step();
        check("t6_out_pc0", out_pc, 32'hFFFFFFFC);
        step();
        check("t6_out_pc1", out_pc, 32'h00000000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
